// File: rtl/tlc_pkg.sv
// Shared types and constants for the four-way traffic-light phase scheduler.
package tlc_pkg;

  localparam logic [1:0] LightRed    = 2'b00;
  localparam logic [1:0] LightYellow = 2'b01;
  localparam logic [1:0] LightGreen  = 2'b10;

  localparam logic [1:0] DirNorth = 2'd0;
  localparam logic [1:0] DirEast  = 2'd1;
  localparam logic [1:0] DirSouth = 2'd2;
  localparam logic [1:0] DirWest  = 2'd3;

  typedef enum logic [1:0] {
    StAllRed,
    StGreen,
    StYellow,
    StEmergGreen
  } state_e;

endpackage

// File: rtl/tlc_rr_picker.sv
// Next-owner selection: fixed-priority emergency pick, else round-robin over requests.
module tlc_rr_picker
  import tlc_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] emergency,
  input  logic [1:0] last_served,
  output logic [1:0] sel_dir,
  output logic       sel_valid,
  output logic       sel_emerg
);

  always_comb begin
    sel_dir   = DirNorth;
    sel_valid = 1'b0;
    sel_emerg = 1'b0;
    if (|emergency) begin
      sel_valid = 1'b1;
      sel_emerg = 1'b1;
      if (emergency[DirNorth])     sel_dir = DirNorth;
      else if (emergency[DirEast]) sel_dir = DirEast;
      else if (emergency[DirSouth]) sel_dir = DirSouth;
      else                         sel_dir = DirWest;
    end else begin
      // Walk offsets 4..1 so the smallest offset from last_served wins; offset 4 is itself.
      for (int i = 4; i >= 1; i--) begin
        if (req[2'(last_served + 2'(i))]) begin
          sel_dir   = 2'(last_served + 2'(i));
          sel_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Four-way traffic-light phase FSM with min/max green, yellow and all-red clearance, and
// emergency preemption. All outputs come straight from flops.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 32,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] emergency,
  output logic [1:0] North_r,
  output logic [1:0] East_r,
  output logic [1:0] South_r,
  output logic [1:0] West_r,
  output logic [1:0] green_dir,
  output logic       green_valid,
  output logic       emerg_active
);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      dir_q, dir_d;
  logic [1:0]      last_q, last_d;
  logic [3:0][1:0] lights_q, lights_d;
  logic            valid_q, emerg_q;

  logic [1:0] sel_dir;
  logic       sel_valid, sel_emerg;
  logic       others_req;

  tlc_rr_picker u_picker (
    .req         (req),
    .emergency   (emergency),
    .last_served (last_q),
    .sel_dir     (sel_dir),
    .sel_valid   (sel_valid),
    .sel_emerg   (sel_emerg)
  );

  assign others_req = |(req & ~(4'b0001 << dir_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    last_d  = last_q;
    unique case (state_q)
      StAllRed: begin
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else if (sel_valid) begin
          dir_d   = sel_dir;
          last_d  = sel_dir;
          cnt_d   = 8'd1;
          state_d = sel_emerg ? StEmergGreen : StGreen;
        end
      end
      StGreen: begin
        // Counts elapsed green cycles, saturating so a resting green never wraps.
        if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        if (emergency[dir_q]) begin
          state_d = StEmergGreen;
          cnt_d   = 8'd1;
        end else if ((|emergency) ||
                     (others_req && ((cnt_q >= 8'(MIN_GREEN)) || (cnt_q >= 8'(MAX_GREEN))))) begin
          state_d = StYellow;
          cnt_d   = 8'(YELLOW_T);
        end
      end
      StYellow: begin
        if (cnt_q > 8'd1) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = StAllRed;
          cnt_d   = 8'(ALLRED_T);
        end
      end
      StEmergGreen: begin
        if (!emergency[dir_q]) begin
          state_d = StYellow;
          cnt_d   = 8'(YELLOW_T);
        end
      end
      default: begin
        state_d = StAllRed;
        cnt_d   = 8'(ALLRED_T);
      end
    endcase
  end

  always_comb begin
    lights_d = {4{LightRed}};
    if (state_d == StGreen || state_d == StEmergGreen) lights_d[dir_d] = LightGreen;
    else if (state_d == StYellow)                      lights_d[dir_d] = LightYellow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StAllRed;
      cnt_q    <= 8'(ALLRED_T);
      dir_q    <= DirNorth;
      last_q   <= DirWest;
      lights_q <= {4{LightRed}};
      valid_q  <= 1'b0;
      emerg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      last_q   <= last_d;
      lights_q <= lights_d;
      valid_q  <= (state_d != StAllRed);
      emerg_q  <= (state_d == StEmergGreen);
    end
  end

  assign North_r      = lights_q[DirNorth];
  assign East_r       = lights_q[DirEast];
  assign South_r      = lights_q[DirSouth];
  assign West_r       = lights_q[DirWest];
  assign green_dir    = dir_q;
  assign green_valid  = valid_q;
  assign emerg_active = emerg_q;

endmodule

// File: doc/tlc_phase_scheduler.md
TLC_PHASE_SCHEDULER -- requirements
Module: tlc_phase_scheduler

Interface
REQ-001 Parameters SHALL be:
  - MIN_GREEN, 8, minimum green cycles
  - MAX_GREEN, 32, green cycles before forced rotation
  - YELLOW_T, 4, yellow cycles
  - ALLRED_T, 2, all-red clearance cycles
  - Each is 1..255, with MIN_GREEN <= MAX_GREEN.
REQ-002 Ports SHALL be (direction index 0=North, 1=East, 2=South, 3=West):
  - clk  in  1  system clock
  - rst_n  in  1  reset; one clock; reset is asynchronous and active-low
  - req  in  4  vehicle-presence request per direction, level
  - emergency  in  4  emergency preemption per direction, level
  - North_r  out  2  North light
  - East_r  out  2  East light
  - South_r  out  2  South light
  - West_r  out  2  West light
  - green_dir  out  2  index of direction currently green or yellow
  - green_valid  out  1  high when any light is non-RED
  - emerg_active  out  1  high while in EMERG_GREEN

Function
REQ-003 Light encoding SHALL be RED=2'b00, YELLOW=2'b01, GREEN=2'b10; 2'b11 is never driven.
REQ-004 At most one direction SHALL be non-RED in any cycle.
REQ-005 All outputs SHALL be registered and change only on rising clk.
REQ-006 FSM states SHALL be ALL_RED, GREEN, YELLOW and EMERG_GREEN, with one 8-bit dwell counter reloaded on every state entry.
REQ-007 ALL_RED SHALL last exactly ALLRED_T cycles; on its final cycle the next owner is selected as follows:
  - If any emergency bit is set: the lowest-index set bit; next state EMERG_GREEN.
  - Else if any req bit is set: round-robin search starting at last_served+1 mod 4; next state GREEN.
  - Else: remain in ALL_RED with the counter held expired, re-evaluating every cycle.
REQ-008 The selected direction's light SHALL show GREEN on the first cycle after selection, and last_served SHALL update to it.
REQ-009 GREEN SHALL exit to YELLOW at the end of a cycle where any of the following holds:
  - any emergency bit is set (MIN_GREEN ignored), or
  - at least MIN_GREEN cycles have elapsed and some other direction has req set, or
  - MAX_GREEN cycles have elapsed and some other direction has req set.
  With no competing request, GREEN SHALL rest indefinitely past MAX_GREEN.
REQ-010 If emergency[d] is set for the current green direction d, GREEN SHALL transfer directly to EMERG_GREEN with no yellow.
REQ-011 YELLOW SHALL last exactly YELLOW_T cycles and then enter ALL_RED; emergencies SHALL NOT shorten YELLOW or ALL_RED.
REQ-012 EMERG_GREEN SHALL hold its direction GREEN while that emergency bit stays high, ignoring changes on other emergency bits and on req.
REQ-013 When the held emergency bit drops, EMERG_GREEN SHALL go to YELLOW, then ALL_RED.
REQ-014 Simultaneous emergencies SHALL resolve by fixed priority North > East > South > West.
REQ-015 emerg_active SHALL be high exactly in EMERG_GREEN.
REQ-016 green_dir SHALL hold the last owner while in ALL_RED.

Reset
REQ-017 While rst_n is low, the block SHALL hold:
  - state ALL_RED, counter reloaded to ALLRED_T
  - last_served = 3, so North is searched first
  - all lights RED, green_dir 0, green_valid 0, emerg_active 0
REQ-018 Reset assertion mid-phase SHALL force all lights RED asynchronously, within the same cycle.
REQ-019 After rst_n rises, the first ALL_RED interval SHALL run a full ALLRED_T cycles.

Structure
REQ-020 Package tlc_pkg SHALL hold:
  - light encodings
  - the state enum
  - direction index constants
REQ-021 Round-robin and priority selection SHALL live in one combinational sub-module, tlc_rr_picker, with inputs req, emergency and last_served and outputs sel_dir, sel_valid and sel_emerg.

Verification
REQ-022 Reset release with req=4'b0000, emergency=0 -> all lights stay RED and green_valid=0 for 100 cycles.
REQ-023 req=4'b1111 held (default parameters) -> GREEN order N, E, S, W, N:
  - each GREEN lasts 8 cycles, YELLOW 4, ALL_RED 2
  - period 56 cycles.
REQ-024 req=4'b0001 only -> North reaches GREEN and stays GREEN for 200+ cycles.
REQ-025 While North has been GREEN 3 cycles with req=4'b0011, set emergency=4'b0100 -> sequence:
  - North YELLOW for 4 cycles
  - ALL_RED for 2 cycles
  - South GREEN with emerg_active=1 until emergency clears
  - then South YELLOW
REQ-026 emergency=4'b1010 from ALL_RED -> East receives EMERG_GREEN; raising emergency[0] afterwards does not preempt East.
REQ-027 rst_n pulsed low mid-YELLOW -> lights go RED immediately; after release the bench sees ALL_RED for 2 cycles, then North first.
REQ-028 Every scenario SHALL carry checkers for:
  - at most one non-RED light
  - 2'b11 never driven
